c2670_resp_misr: RTL



---
 rtl/c2670_resp_misr.sv | 95 +++++++++
 1 files changed

// File: rtl/c2670_resp_misr.sv
// Response compactor for c2670: XOR-folds each 140-bit response to 32 bits and
// accumulates it into a Galois MISR. Optional golden compare: MISR_GOLDEN_CMP_EN.
module c2670_resp_misr #(
    parameter int          WIDTH       = 140,
    parameter int          NUM_VECTORS = 8,
    parameter logic [31:0] SEED        = 32'h0000_0000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               resp_valid,
    input  logic [WIDTH-1:0]                   resp_data,
    output logic                               resp_ready,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count,
    output logic [31:0]                        signature,
    input  logic [31:0]                        golden,
    output logic                               pass
);

    localparam int          CW     = $clog2(NUM_VECTORS + 1);
    localparam int          NCHUNK = (WIDTH + 31) / 32;
    localparam logic [31:0] POLY   = 32'h0040_0007;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VECTORS - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(NUM_VECTORS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [NCHUNK*32-1:0] padded;
    logic [31:0]          fold;
    logic [31:0]          misr_next;
    logic                 accept;
    logic                 last;

    // Zero-extend to a whole number of 32-bit chunks before folding
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = resp_data;
        fold = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            fold = fold ^ padded[k*32 +: 32];
        end
        misr_next = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
    end

    assign accept = (state == RUN) && resp_valid && !start;
    assign last   = (vec_count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            signature  <= SEED;
            vec_count  <= '0;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MISR_GOLDEN_CMP_EN
            pass       <= 1'b0;
`endif
        end else if (start) begin
            state      <= RUN;
            signature  <= SEED;
            vec_count  <= '0;
            resp_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
`ifdef MISR_GOLDEN_CMP_EN
            pass       <= 1'b0;
`endif
        end else if (accept) begin
            signature <= misr_next;
            if (vec_count != MAX_CNT) begin
                vec_count <= vec_count + CW'(1);
            end
            if (last) begin
                state      <= DONE;
                resp_ready <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
`ifdef MISR_GOLDEN_CMP_EN
                pass       <= (misr_next == golden);
`endif
            end
        end
    end

`ifndef MISR_GOLDEN_CMP_EN
    logic unused_golden;
    assign unused_golden = ^golden;
    assign pass = 1'b0;
`endif

endmodule
